memwb_skid_stage: RTL and testbench

- Parametrised, elastic MEM/WB pipeline stage for the 5-stage MIPS core.
- Replaces the fixed always-load MEM/WB register with a 2-entry valid/ready skid stage, and adds:
  - synchronous flush;
  - write-back data select at capture;
  - $zero write suppression;
  - a forwarding lookup port.
- Sits between the data-memory stage and the register-file write port, so a stalled register-file or writeback arbiter no longer needs a global pipeline freeze.

---
 rtl/memwb_skid_stage_if.sv | 39 +++
 rtl/memwb_skid_stage.sv | 197 +++++++++++++++++++
 tb/tb_memwb_skid_stage.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memwb_skid_stage_if.sv
// MEM/WB beat bus: upstream valid/ready beat from the memory stage and the
// downstream head beat toward the register-file write port.
interface memwb_skid_stage_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [DATA_W-1:0] in_rdata;
  logic [DATA_W-1:0] in_alures;
  logic [DEST_W-1:0] in_dest;
  logic [CTRL_W-1:0] in_ctrl;

  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_wbdata;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: produces upstream beats and consumes head beats.
  modport master (
    output in_valid, in_regwrite, in_memtoreg, in_rdata, in_alures, in_dest, in_ctrl,
    input  in_ready,
    input  out_valid, out_regwrite, out_dest, out_wbdata, out_ctrl,
    output out_ready
  );

  // Stage side.
  modport slave (
    input  in_valid, in_regwrite, in_memtoreg, in_rdata, in_alures, in_dest, in_ctrl,
    output in_ready,
    output out_valid, out_regwrite, out_dest, out_wbdata, out_ctrl,
    input  out_ready
  );
endinterface

// File: rtl/memwb_skid_stage.sv
// Elastic 2-entry MEM/WB stage: HEAD drives the write-back port, SKID holds
// the younger beat while downstream stalls. Write-back data is selected and
// $zero writes are suppressed at capture. Forwarding lookup prefers SKID.
module memwb_skid_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  memwb_skid_stage_if.slave    bus,
  input  logic [DEST_W-1:0]    fwd_query,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic              head_regwrite_r;
  logic [DEST_W-1:0] head_dest_r;
  logic [DATA_W-1:0] head_wbdata_r;
  logic [CTRL_W-1:0] head_ctrl_r;

  logic              skid_regwrite_r;
  logic [DEST_W-1:0] skid_dest_r;
  logic [DATA_W-1:0] skid_wbdata_r;
  logic [CTRL_W-1:0] skid_ctrl_r;

  logic              head_valid_s;
  logic              skid_valid_s;
  logic              accept_s;
  logic              retire_s;
  logic              cap_regwrite_s;
  logic [DATA_W-1:0] cap_wbdata_s;

  logic              load_head_in_s;
  logic              load_head_skid_s;
  logic              load_skid_s;
  logic              clear_s;

  logic              head_match_s;
  logic              skid_match_s;

  // Entry valids are pure decodes of the occupancy state.
  assign head_valid_s = (state_r != EMPTY);
  assign skid_valid_s = (state_r == FULL);

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  assign bus.in_ready  = ~skid_valid_s;
  assign bus.out_valid = head_valid_s;
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign retire_s      = head_valid_s & bus.out_ready;

  // Capture transform: memtoreg is consumed here and never stored.
  assign cap_wbdata_s   = bus.in_memtoreg ? bus.in_rdata : bus.in_alures;
  assign cap_regwrite_s = bus.in_regwrite & (bus.in_dest != {DEST_W{1'b0}});

  assign bus.out_regwrite = head_valid_s & head_regwrite_r;
  assign bus.out_dest     = head_dest_r;
  assign bus.out_wbdata   = head_wbdata_r;
  assign bus.out_ctrl     = head_ctrl_r;
  assign occupancy        = state_r;

  // Next-state and entry load selection; flush overrides every handshake.
  always_comb begin
    state_next_s     = state_r;
    load_head_in_s   = 1'b0;
    load_head_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    clear_s          = 1'b0;
    if (flush) begin
      state_next_s = EMPTY;
      clear_s      = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_next_s   = ONE;
            load_head_in_s = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && retire_s) begin
            state_next_s   = ONE;
            load_head_in_s = 1'b1;
          end else if (accept_s) begin
            state_next_s = FULL;
            load_skid_s  = 1'b1;
          end else if (retire_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        FULL: begin
          if (retire_s) begin
            state_next_s     = ONE;
            load_head_skid_s = 1'b1;
          end else begin
            state_next_s = FULL;
          end
        end
        default: begin
          state_next_s = EMPTY;
          clear_s      = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // HEAD payload: cleared by reset/flush, loaded from input or promoted from SKID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_regwrite_r <= 1'b0;
      head_dest_r     <= {DEST_W{1'b0}};
      head_wbdata_r   <= {DATA_W{1'b0}};
      head_ctrl_r     <= {CTRL_W{1'b0}};
    end else if (clear_s) begin
      head_regwrite_r <= 1'b0;
      head_dest_r     <= {DEST_W{1'b0}};
      head_wbdata_r   <= {DATA_W{1'b0}};
      head_ctrl_r     <= {CTRL_W{1'b0}};
    end else if (load_head_in_s) begin
      head_regwrite_r <= cap_regwrite_s;
      head_dest_r     <= bus.in_dest;
      head_wbdata_r   <= cap_wbdata_s;
      head_ctrl_r     <= bus.in_ctrl;
    end else if (load_head_skid_s) begin
      head_regwrite_r <= skid_regwrite_r;
      head_dest_r     <= skid_dest_r;
      head_wbdata_r   <= skid_wbdata_r;
      head_ctrl_r     <= skid_ctrl_r;
    end
  end

  // SKID payload: written only when a beat arrives while HEAD is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_regwrite_r <= 1'b0;
      skid_dest_r     <= {DEST_W{1'b0}};
      skid_wbdata_r   <= {DATA_W{1'b0}};
      skid_ctrl_r     <= {CTRL_W{1'b0}};
    end else if (clear_s) begin
      skid_regwrite_r <= 1'b0;
      skid_dest_r     <= {DEST_W{1'b0}};
      skid_wbdata_r   <= {DATA_W{1'b0}};
      skid_ctrl_r     <= {CTRL_W{1'b0}};
    end else if (load_skid_s) begin
      skid_regwrite_r <= cap_regwrite_s;
      skid_dest_r     <= bus.in_dest;
      skid_wbdata_r   <= cap_wbdata_s;
      skid_ctrl_r     <= bus.in_ctrl;
    end
  end

  assign head_match_s = head_valid_s & head_regwrite_r & (head_dest_r == fwd_query) &
                        (fwd_query != {DEST_W{1'b0}});
  assign skid_match_s = skid_valid_s & skid_regwrite_r & (skid_dest_r == fwd_query) &
                        (fwd_query != {DEST_W{1'b0}});

  // Forwarding result: the younger SKID entry wins over HEAD.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    if (skid_match_s) begin
      fwd_hit  = 1'b1;
      fwd_data = skid_wbdata_r;
    end else if (head_match_s) begin
      fwd_hit  = 1'b1;
      fwd_data = head_wbdata_r;
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Bench for memwb_skid_stage: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_memwb_skid_stage;
  localparam int DW = 32;
  localparam int EW = 5;
  localparam int CW = 4;

  typedef struct {
    logic          rw;
    logic [EW-1:0] dest;
    logic [DW-1:0] wb;
    logic [CW-1:0] ctrl;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [EW-1:0] fwd_query = '0;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_err = 0;

  ent_t q[$];
  ent_t shown;

  memwb_skid_stage_if #(.DATA_W(DW), .DEST_W(EW), .CTRL_W(CW)) bus ();

  memwb_skid_stage #(.DATA_W(DW), .DEST_W(EW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .fwd_query (fwd_query),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic rw, input logic m, input logic [DW-1:0] rd,
                      input logic [DW-1:0] al, input logic [EW-1:0] d, input logic [CW-1:0] c);
    bus.in_valid    = v;
    bus.in_regwrite = rw;
    bus.in_memtoreg = m;
    bus.in_rdata    = rd;
    bus.in_alures   = al;
    bus.in_dest     = d;
    bus.in_ctrl     = c;
  endtask

  // Reference model: a FIFO of at most two beats, updated at each edge.
  initial begin
    ent_t nb;
    bit acc, ret;
    shown = '{rw: 1'b0, dest: '0, wb: '0, ctrl: '0};
    forever begin
      @(posedge clk or negedge rst);
      if (!rst || flush) begin
        q.delete();
        shown = '{rw: 1'b0, dest: '0, wb: '0, ctrl: '0};
      end else begin
        acc = bus.in_valid && (q.size() < 2);
        ret = (q.size() > 0) && bus.out_ready;
        if (ret) void'(q.pop_front());
        if (acc) begin
          nb.rw   = bus.in_regwrite && (bus.in_dest != 0);
          nb.dest = bus.in_dest;
          nb.wb   = bus.in_memtoreg ? bus.in_rdata : bus.in_alures;
          nb.ctrl = bus.in_ctrl;
          q.push_back(nb);
        end
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    logic          eh;
    logic [DW-1:0] ed;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("m_occupancy", occupancy, q.size());
      chk("m_in_ready", bus.in_ready, q.size() < 2);
      chk("m_out_valid", bus.out_valid, q.size() > 0);
      chk("m_out_regwrite", bus.out_regwrite, (q.size() > 0) && shown.rw);
      chk("m_out_dest", bus.out_dest, shown.dest);
      chk("m_out_wbdata", bus.out_wbdata, shown.wb);
      chk("m_out_ctrl", bus.out_ctrl, shown.ctrl);
      eh = 1'b0;
      ed = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!eh && q[i].rw && q[i].dest == fwd_query && fwd_query != 0) begin
          eh = 1'b1;
          ed = q[i].wb;
        end
      end
      chk("m_fwd_hit", fwd_hit, eh);
      chk("m_fwd_data", fwd_data, ed);
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    beat(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) step();
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_wbdata", bus.out_wbdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    rst = 1'b1;
    step();

    // Streaming at one beat per cycle.
    bus.out_ready = 1'b1;
    beat(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1, 5'd8, 4'd3);
    step();
    chk("s1_out_valid", bus.out_valid, 1);
    chk("s1_out_wbdata", bus.out_wbdata, 32'hDEADBEEF);
    chk("s1_out_dest", bus.out_dest, 8);
    chk("s1_out_regwrite", bus.out_regwrite, 1);
    beat(1'b1, 1'b1, 1'b0, 32'hCAFE0000, 32'h1234, 5'd9, 4'd5);
    step();
    chk("s2_out_wbdata", bus.out_wbdata, 32'h1234);
    chk("s2_out_dest", bus.out_dest, 9);
    chk("s2_occupancy", occupancy, 1);
    bus.in_valid = 1'b0;
    step();
    chk("s3_occupancy", occupancy, 0);
    chk("s3_hold_wbdata", bus.out_wbdata, 32'h1234);

    // Backpressure with three offered beats.
    bus.out_ready = 1'b0;
    beat(1'b1, 1'b1, 1'b0, '0, 32'h101, 5'd1, 4'd1);
    step();
    chk("b1_occupancy", occupancy, 1);
    chk("b1_in_ready", bus.in_ready, 1);
    beat(1'b1, 1'b1, 1'b0, '0, 32'h102, 5'd2, 4'd2);
    step();
    chk("b2_occupancy", occupancy, 2);
    chk("b2_in_ready", bus.in_ready, 0);
    beat(1'b1, 1'b1, 1'b0, '0, 32'h103, 5'd3, 4'd3);
    step();
    chk("b3_occupancy", occupancy, 2);
    chk("b3_out_dest", bus.out_dest, 1);
    bus.out_ready = 1'b1;
    step();
    chk("b4_out_dest", bus.out_dest, 2);
    chk("b4_occupancy", occupancy, 1);
    step();
    chk("b5_out_dest", bus.out_dest, 3);
    chk("b5_out_wbdata", bus.out_wbdata, 32'h103);
    bus.in_valid = 1'b0;
    step();
    chk("b6_occupancy", occupancy, 0);

    // $zero write suppression.
    bus.out_ready = 1'b0;
    beat(1'b1, 1'b1, 1'b0, '0, 32'h55, 5'd0, 4'd0);
    step();
    bus.in_valid = 1'b0;
    fwd_query = 5'd0;
    #1;
    chk("z_out_valid", bus.out_valid, 1);
    chk("z_out_regwrite", bus.out_regwrite, 0);
    chk("z_fwd_hit", fwd_hit, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Forwarding priority: SKID is younger than HEAD.
    beat(1'b1, 1'b1, 1'b0, '0, 32'h10, 5'd5, 4'd0);
    step();
    beat(1'b1, 1'b1, 1'b0, '0, 32'h20, 5'd5, 4'd0);
    step();
    bus.in_valid = 1'b0;
    fwd_query = 5'd5;
    #1;
    chk("f1_fwd_hit", fwd_hit, 1);
    chk("f1_fwd_data", fwd_data, 32'h20);
    fwd_query = 5'd6;
    #1;
    chk("f2_fwd_hit", fwd_hit, 0);
    chk("f2_fwd_data", fwd_data, 0);
    fwd_query = 5'd5;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("f3_occupancy", occupancy, 1);
    chk("f3_fwd_data", fwd_data, 32'h20);

    // Flush while FULL with retire and an offered beat.
    beat(1'b1, 1'b1, 1'b0, '0, 32'h70, 5'd7, 4'd7);
    step();
    chk("c1_occupancy", occupancy, 2);
    beat(1'b1, 1'b1, 1'b0, '0, 32'hAA, 5'd10, 4'd9);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("c2_occupancy", occupancy, 0);
    chk("c2_out_valid", bus.out_valid, 0);
    chk("c2_out_wbdata", bus.out_wbdata, 0);
    chk("c2_in_ready", bus.in_ready, 1);
    // Flush while an accept is high: the beat is discarded.
    beat(1'b1, 1'b1, 1'b0, '0, 32'hB0, 5'd11, 4'd1);
    step();
    beat(1'b1, 1'b1, 1'b0, '0, 32'hC0, 5'd12, 4'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("c3_occupancy", occupancy, 0);
    chk("c3_out_dest", bus.out_dest, 0);

    // Asynchronous reset with two held entries.
    beat(1'b1, 1'b1, 1'b1, 32'hD0, '0, 5'd13, 4'd4);
    step();
    beat(1'b1, 1'b1, 1'b1, 32'hE0, '0, 5'd14, 4'd6);
    step();
    bus.in_valid = 1'b0;
    fwd_query = 5'd14;
    chk("a0_occupancy", occupancy, 2);
    #2 rst = 1'b0;
    #1;
    chk("a1_occupancy", occupancy, 0);
    chk("a1_out_valid", bus.out_valid, 0);
    chk("a1_in_ready", bus.in_ready, 1);
    chk("a1_out_regwrite", bus.out_regwrite, 0);
    chk("a1_out_dest", bus.out_dest, 0);
    chk("a1_out_wbdata", bus.out_wbdata, 0);
    chk("a1_out_ctrl", bus.out_ctrl, 0);
    chk("a1_fwd_hit", fwd_hit, 0);
    chk("a1_fwd_data", fwd_data, 0);
    step();
    rst = 1'b1;
    step();

    // Random traffic; small destination range to provoke forwarding matches.
    for (int n = 0; n < 3000; n++) begin
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom(), $urandom(), $urandom_range(0, 7), $urandom_range(0, 15));
      bus.out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 31) == 0);
      fwd_query = $urandom_range(0, 7);
      step();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
